// File: rtl/filter_window.sv
// filter_window
//   Turns the column stream from the delay stage into WIDTH_NB x HEIGHT_NB
//   pixel windows for the filter arithmetic. Columns are shifted into a
//   horizontal register, and the column position within the image row is
//   tracked. A window is emitted only when all of its columns belong to the
//   same row. The last window of each row is flagged.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   cfg_width  columns per image row; sampled on cfg_set
//   cfg_set    latch cfg_width and restart row tracking
//   up_data    input column; pixel h at [h*IMG_WIDTH +: IMG_WIDTH]
//   up_val     up_data valid
//   dn_data    window; pixel (w,h) at [(w*HEIGHT_NB+h)*IMG_WIDTH +: IMG_WIDTH],
//              where w=0 is the newest column
//   dn_val     dn_data holds a complete window
//   dn_last    window ends the current row (only together with dn_val)
module filter_window #(
  parameter int HEIGHT_NB = 3,
  parameter int WIDTH_NB  = 3,
  parameter int IMG_WIDTH = 8,
  parameter int CNT_WIDTH = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CNT_WIDTH-1:0]                  cfg_width,
  input  logic                                  cfg_set,
  input  logic [IMG_WIDTH*HEIGHT_NB-1:0]        up_data,
  input  logic                                  up_val,
  output logic [IMG_WIDTH*HEIGHT_NB*WIDTH_NB-1:0] dn_data,
  output logic                                  dn_val,
  output logic                                  dn_last
);

  localparam int COL_W = IMG_WIDTH * HEIGHT_NB;
  localparam int WIN_W = COL_W * WIDTH_NB;

  // First column index at which the register holds a full window.
  localparam logic [CNT_WIDTH-1:0] RUN_COL = CNT_WIDTH'(WIDTH_NB - 1);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] width_q, width_d;
  logic [CNT_WIDTH-1:0] col_q, col_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic                 val_q, val_d;
  logic                 last_q, last_d;

  logic [CNT_WIDTH-1:0] col_next;
  logic                 row_end;
  logic                 wrap;
  logic                 at_run;

  // A zero width never matches a column index, so it needs its own wrap term
  // to keep col pinned at 0.
  assign row_end = (width_q != '0) && (col_q == width_q - ONE);
  assign wrap    = (width_q == '0) || row_end;
  assign at_run  = (width_q != '0) && (col_q >= RUN_COL);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; an unassigned path would infer a latch.
    state_d  = state_q;
    width_d  = width_q;
    col_d    = col_q;
    win_d    = win_q;
    val_d    = 1'b0;
    last_d   = 1'b0;
    col_next = wrap ? '0 : col_q + ONE;

    if (cfg_set) begin
      // Restart the row; a coincident column is dropped and the window
      // register keeps its contents.
      width_d = cfg_width;
      col_d   = '0;
      state_d = ST_FILL;
    end else if (up_val && (state_q != ST_IDLE)) begin
      win_d[COL_W-1:0] = up_data;
      for (int w = 1; w < WIDTH_NB; w++) begin
        win_d[w*COL_W +: COL_W] = win_q[(w-1)*COL_W +: COL_W];
      end
      val_d   = at_run;
      last_d  = at_run && row_end;
      col_d   = col_next;
      state_d = (col_next >= RUN_COL) ? ST_RUN : ST_FILL;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      width_q <= '0;
      col_q   <= '0;
      // NOTE: the window register is data, but it drives dn_data directly
      // and must read 0 out of reset, so it is reset with the control state.
      win_q   <= '0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      col_q   <= col_d;
      win_q   <= win_d;
      val_q   <= val_d;
      last_q  <= last_d;
    end
  end

  assign dn_data = win_q;
  assign dn_val  = val_q;
  assign dn_last = last_q;

endmodule

// File: tb/tb_filter_window.sv
// Scoreboard bench for filter_window: stimulus pushes expected windows into
// a queue, a negedge monitor pops and compares whenever dn_val is high.
module tb_filter_window;

  localparam int H     = 3;
  localparam int W     = 3;
  localparam int IW    = 8;
  localparam int CW    = 12;
  localparam int COL_W = IW * H;
  localparam int WIN_W = COL_W * W;

  logic               clk;
  logic               rst;
  logic [CW-1:0]      cfg_width;
  logic               cfg_set;
  logic [COL_W-1:0]   up_data;
  logic               up_val;
  logic [WIN_W-1:0]   dn_data;
  logic               dn_val;
  logic               dn_last;

  filter_window #(
    .HEIGHT_NB (H),
    .WIDTH_NB  (W),
    .IMG_WIDTH (IW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_width (cfg_width),
    .cfg_set   (cfg_set),
    .up_data   (up_data),
    .up_val    (up_val),
    .dn_data   (dn_data),
    .dn_val    (dn_val),
    .dn_last   (dn_last)
  );

  typedef struct {
    logic [WIN_W-1:0] data;
    logic             last;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_win  = 0;
  int   n_last = 0;
  int   cyc    = 0;

  // Reference model state.
  logic             m_active;
  logic [CW-1:0]    m_width;
  logic [CW-1:0]    m_col;
  logic [WIN_W-1:0] m_win;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [COL_W-1:0] colv(input int c);
    logic [IW-1:0] p;
    p = c[IW-1:0];
    return {p, p, p};
  endfunction

  // Drive one cycle of stimulus and advance the model; outputs are then
  // sampled 1 time unit after the capturing edge.
  task automatic beat(input logic [COL_W-1:0] d, input logic v,
                      input logic cs, input logic [CW-1:0] cw);
    up_data   = d;
    up_val    = v;
    cfg_set   = cs;
    cfg_width = cw;
    if (cs) begin
      m_active = 1'b1;
      m_width  = cw;
      m_col    = '0;
    end else if (v && m_active) begin
      m_win = {m_win[WIN_W-COL_W-1:0], d};
      if (m_width != 0 && m_col >= CW'(W - 1))
        q.push_back('{data: m_win, last: (m_col == m_width - 1), cyc: cyc + 1});
      m_col = (m_width == 0 || m_col == m_width - 1) ? '0 : m_col + 1;
    end
    @(posedge clk);
    #1;
    up_val  = 1'b0;
    cfg_set = 1'b0;
  endtask

  // Monitor: compares every presented window against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    check("last_implies_val", {127'd0, dn_last & ~dn_val}, 128'd0);
    if (dn_val === 1'b1) begin
      n_win++;
      if (dn_last) n_last++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: dn_val=1 data=%0h with nothing expected", dn_data);
      end else begin
        e = q.pop_front();
        check("win_data", dn_data, e.data);
        check("win_last", dn_last, e.last);
        check("win_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    cfg_width = '0; cfg_set = 1'b0; up_data = '0; up_val = 1'b0;
    m_active = 1'b0; m_width = '0; m_col = '0; m_win = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_val", dn_val, 0);
    check("rst_last", dn_last, 0);
    check("rst_data", dn_data, 0);
    check("rst_col", dut.col_q, 0);
    rst = 1'b1;

    // IDLE: columns ignored until cfg_set.
    n_win = 0;
    for (int i = 0; i < 5; i++) beat(colv(i + 1), 1'b1, 1'b0, 12'd6);
    beat('0, 1'b0, 1'b0, 12'd6);
    check("idle_windows", n_win, 0);
    check("idle_data", dn_data, 0);
    beat('0, 1'b0, 1'b1, 12'd6);
    check("cfg_col", dut.col_q, 0);

    // Single row; cfg_width wiggles without cfg_set and must be ignored.
    n_win = 0; n_last = 0;
    for (int c = 0; c < 6; c++) begin
      beat(colv(c), 1'b1, 1'b0, 12'd2);
      if (c == 2) begin
        check("row_first_val", dn_val, 1);
        check("row_first_data", dn_data, 72'h000000_010101_020202);
      end
    end
    beat('0, 1'b0, 1'b0, 12'd2);
    beat('0, 1'b0, 1'b0, 12'd2);
    check("row_windows", n_win, 4);
    check("row_lasts", n_last, 1);

    // Two rows back to back.
    beat('0, 1'b0, 1'b1, 12'd6);
    n_win = 0; n_last = 0;
    for (int c = 0; c < 12; c++) begin
      beat(colv(c), 1'b1, 1'b0, 12'd6);
      if (c == 6) check("wrap_no_span", dn_val, 0);
      if (c == 8) check("wrap_row2_data", dn_data, 72'h060606_070707_080808);
    end
    beat('0, 1'b0, 1'b0, 12'd6);
    beat('0, 1'b0, 1'b0, 12'd6);
    check("wrap_windows", n_win, 8);
    check("wrap_lasts", n_last, 2);

    // Gapped input.
    beat('0, 1'b0, 1'b1, 12'd6);
    n_win = 0; n_last = 0;
    for (int c = 0; c < 6; c++) begin
      beat(colv(c + 32), 1'b1, 1'b0, 12'd6);
      beat('0, 1'b0, 1'b0, 12'd6);
      check("gap_idle_val", dn_val, 0);
    end
    beat('0, 1'b0, 1'b0, 12'd6);
    check("gap_windows", n_win, 4);
    check("gap_lasts", n_last, 1);

    // Narrow row: width below window width.
    beat('0, 1'b0, 1'b1, 12'd2);
    n_win = 0;
    for (int k = 0; k < 10; k++) begin
      beat(colv(k), 1'b1, 1'b0, 12'd2);
      check("narrow_col", dut.col_q, (k + 1) % 2);
    end
    beat('0, 1'b0, 1'b0, 12'd2);
    check("narrow_windows", n_win, 0);

    // Mid-row cfg_set coincident with a column.
    beat('0, 1'b0, 1'b1, 12'd6);
    for (int c = 0; c < 3; c++) beat(colv(c), 1'b1, 1'b0, 12'd6);
    beat(colv(8'hAA), 1'b1, 1'b1, 12'd6);
    check("midcfg_col", dut.col_q, 0);
    check("midcfg_val", dn_val, 0);
    check("midcfg_data_kept", dn_data, 72'h000000_010101_020202);
    beat(colv(8'h10), 1'b1, 1'b0, 12'd6);
    check("midcfg_fill1", dn_val, 0);
    beat(colv(8'h11), 1'b1, 1'b0, 12'd6);
    check("midcfg_fill2", dn_val, 0);
    beat(colv(8'h12), 1'b1, 1'b0, 12'd6);
    check("midcfg_window", dn_data, 72'h101010_111111_121212);
    beat(colv(8'h13), 1'b1, 1'b0, 12'd6);

    // Asynchronous reset mid-RUN, after the monitor has sampled this window.
    #5;
    rst = 1'b0;
    #1;
    check("arst_val", dn_val, 0);
    check("arst_data", dn_data, 0);
    check("arst_col", dut.col_q, 0);
    m_active = 1'b0; m_width = '0; m_col = '0; m_win = '0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_win = 0; n_last = 0;
    for (int i = 0; i < 4; i++) beat(colv(i + 64), 1'b1, 1'b0, 12'd3);
    beat('0, 1'b0, 1'b0, 12'd3);
    check("post_rst_idle_windows", n_win, 0);
    check("post_rst_idle_data", dn_data, 0);

    // Exact-width row after reset: a single window, flagged last.
    beat('0, 1'b0, 1'b1, 12'd3);
    for (int c = 1; c <= 3; c++) beat(colv(c), 1'b1, 1'b0, 12'd3);
    beat('0, 1'b0, 1'b0, 12'd3);
    beat('0, 1'b0, 1'b0, 12'd3);
    check("exact_windows", n_win, 1);
    check("exact_lasts", n_last, 1);
    check("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_window.md
# filter_window

Builds a WIDTH_NB x HEIGHT_NB pixel window for the filter from the column stream produced by the delay stage. Each valid input beat is one vertical column of HEIGHT_NB pixels. The block shifts these columns into a horizontal register and tracks the column position within the image row. It emits a window only when all WIDTH_NB columns belong to the same row, and it flags the last window of each row. It sits directly downstream of the delay stage and directly upstream of the filter arithmetic.

## Interface
- HEIGHT_NB, 3, pixels per column (window height); must match the delay stage.
- WIDTH_NB, 3, columns per window (window width), >= 1.
- IMG_WIDTH, 8, bits per pixel.
- CNT_WIDTH, 12, width of the row-length config and column counter.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_width  in  CNT_WIDTH  columns per image row; sampled on cfg_set.
- cfg_set  in  1  latches cfg_width and restarts row tracking.
- up_data  in  IMG_WIDTH*HEIGHT_NB  input column; pixel h at [h*IMG_WIDTH +: IMG_WIDTH].
- up_val  in  1  up_data valid this cycle.
- dn_data  out  IMG_WIDTH*HEIGHT_NB*WIDTH_NB  window; pixel (w,h) at [(w*HEIGHT_NB+h)*IMG_WIDTH +: IMG_WIDTH], w=0 is the newest column.
- dn_val  out  1  dn_data is a complete window.
- dn_last  out  1  window ends the current row; asserted only together with dn_val.

## Operation
- Width register `width_r` and column counter `col` (0..width_r-1) are CNT_WIDTH bits wide.
- State machine:
  - IDLE: state after reset. up_val is ignored. cfg_set moves to FILL.
  - FILL: col < WIDTH_NB-1.
  - RUN: col >= WIDTH_NB-1.
- cfg_set, in any state:
  - width_r <= cfg_width; col <= 0; state <= FILL.
  - The window shift register is not cleared.
  - Has priority over a coincident up_val; that column is dropped (no shift, no count).
- up_val in FILL/RUN, without cfg_set:
  - Shift: column w <= column w-1 for w = WIDTH_NB-1 down to 1; column 0 <= up_data.
  - dn_val <= (col >= WIDTH_NB-1).
  - dn_last <= (col >= WIDTH_NB-1) && (col == width_r-1).
  - Counter: col <= (col == width_r-1) ? 0 : col+1.
  - Wrap returns the state to FILL. Otherwise the state is RUN when the next col >= WIDTH_NB-1.
- Cycles with up_val low: no shift, col held, dn_val <= 0, dn_last <= 0, dn_data held.
- Degenerate widths:
  - width_r < WIDTH_NB: dn_val never asserts. col still counts and wraps.
  - width_r == 0: no window is ever emitted; col stays 0.
- WIDTH_NB == 1: every valid column yields a window. FILL is transient and the state is RUN from col 0.
- Windows emitted per row = width_r - WIDTH_NB + 1 when width_r >= WIDTH_NB.

## Timing
- Reset values: dn_data = 0, dn_val = 0, dn_last = 0, col = 0, width_r = 0, state = IDLE, window register = 0.
- Reset asserted mid-row clears everything immediately (asynchronous). After release the block is in IDLE and needs cfg_set again.
- Latency: an up_val beat at edge N produces dn_val/dn_data/dn_last valid after edge N (registered, 1 cycle).
- No backpressure. The downstream stage must accept one window per cycle.
- Full throughput: up_val high every cycle gives one window per cycle in RUN.
- Gaps in up_val stretch the row; they do not reset position.
- cfg_width changes without cfg_set have no effect.

## Test plan
- Reset and config: hold rst low 3 cycles and release, then drive up_val for 5 cycles without cfg_set -> dn_val stays 0. Then cfg_set with cfg_width=6 -> state FILL, col=0.
- Single row: HEIGHT_NB=3, WIDTH_NB=3, cfg_width=6, six back-to-back columns with pixels = column index -> dn_val on outputs 3..6 (4 windows). The first window has w0 = col 2, w2 = col 0. dn_last only on the 4th window.
- Row wrap: 12 continuous columns, cfg_width=6 -> windows after columns 2-5 and 8-11. No window spans columns 5/6. dn_last twice.
- Gapped input: same as the single-row case with up_val low every other cycle -> identical window sequence. dn_val is 0 on every idle cycle.
- Narrow row: cfg_width=2 with 10 columns -> dn_val never asserts. col alternates 0,1.
- Mid-row events: cfg_set coincident with up_val at col 3 -> column dropped, col=0. The next 2 columns produce no dn_val. Async rst pulse mid-RUN -> outputs 0 immediately, IDLE afterwards.
